// File: rtl/tanhx_pkg.sv
// -----------------------------------------------------------------------------
// tanhx_pkg
// Shared definitions for the tanh(x) stream controller slice:
//   - state_e        : controller FSM states
//   - FP32 constants : zero (burst padding), +1.0 and -1.0
//   - DEFAULT_DWIDTH : operand/result width (IEEE-754 single)
// -----------------------------------------------------------------------------
package tanhx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_DWIDTH = 32;

   localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;
   localparam logic [31:0] FP32_POS_ONE = 32'h3F80_0000;
   localparam logic [31:0] FP32_NEG_ONE = 32'hBF80_0000;

endpackage

// File: rtl/tanhx_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// tanhx_stream_ctrl_if
// Host and activation-unit signals of the tanh(x) stream controller.
//   Host operand side : in_valid, in_data, in_ready
//   Burst control     : go, busy, done, err_timeout
//   Host result side  : out_valid, out_data, out_ready
//   Unit side         : act_start, act_x, act_valid, act_y
// Modports:
//   slave  : view of the controller itself
//   master : view of the environment (host + unit)
// -----------------------------------------------------------------------------
interface tanhx_stream_ctrl_if #(
   parameter int unsigned DWIDTH = tanhx_pkg::DEFAULT_DWIDTH
);
   logic              in_valid;
   logic [DWIDTH-1:0] in_data;
   logic              in_ready;
   logic              go;
   logic              busy;
   logic              done;
   logic              err_timeout;
   logic              out_valid;
   logic [DWIDTH-1:0] out_data;
   logic              out_ready;
   logic              act_start;
   logic [DWIDTH-1:0] act_x;
   logic              act_valid;
   logic [DWIDTH-1:0] act_y;

   modport slave (
      input  in_valid, in_data, go, out_ready, act_valid, act_y,
      output in_ready, busy, done, err_timeout, out_valid, out_data,
             act_start, act_x
   );

   modport master (
      output in_valid, in_data, go, out_ready, act_valid, act_y,
      input  in_ready, busy, done, err_timeout, out_valid, out_data,
             act_start, act_x
   );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO: rdata is the current head whenever !empty.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push, wdata    : write (ignored when full)
//   pop            : remove head (ignored when empty)
//   flush          : synchronous clear, same effect as rst
//   rdata          : head entry
//   full, empty    : status
//   count          : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo
   import tanhx_pkg::*;
#(
   parameter int unsigned DWIDTH = DEFAULT_DWIDTH,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DWIDTH-1:0]        wdata,
   output logic [DWIDTH-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [AW:0]       count_q;
   logic              do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/tanhx_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tanhx_stream_ctrl
// Driving-side controller of the tanh(x) unit. Buffers host operands, streams
// them to the unit as one burst with act_start held high, pads with FP32 zero
// once all operands are sent, and captures exactly n results in operand order.
// Ports:
//   clk  : clock (posedge)
//   rst  : synchronous active-high reset
//   bus  : tanhx_stream_ctrl_if.slave (host operand/result streams, go/busy/
//          done/err_timeout, unit act_start/act_x/act_valid/act_y)
// Build option:
//   TANHX_STREAM_TIMEOUT_EN : enables the watchdog; a STREAM run of TIMEOUT
//                             cycles without act_valid aborts the burst,
//                             flushes both FIFOs and sets err_timeout.
// -----------------------------------------------------------------------------
module tanhx_stream_ctrl
   import tanhx_pkg::*;
#(
   parameter int unsigned DWIDTH  = DEFAULT_DWIDTH,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   tanhx_stream_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     n_q, n_d;
   logic [CW-1:0]     sent_q, sent_d;
   logic [CW-1:0]     recv_q, recv_d;
   logic              act_start_q, act_start_d;
   logic [DWIDTH-1:0] act_x_q, act_x_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              op_push, op_pop, op_full, op_empty;
   logic [DWIDTH-1:0] op_rdata;
   logic [CW-1:0]     op_count;
   logic              res_push, res_pop, res_empty;
   logic [DWIDTH-1:0] res_rdata;
   logic              res_full_unused;
   logic [CW-1:0]     res_count_unused;
   logic              flush;

   logic              in_ready;
   logic              in_wr;
   logic [CW-1:0]     n_avail;
   logic              go_ok;

   assign in_ready = (state_q == ST_IDLE) & ~op_full;
   assign in_wr    = bus.in_valid & in_ready;
   assign n_avail  = op_count + CW'(in_wr);
   assign go_ok    = (state_q == ST_IDLE) & bus.go & (n_avail != '0) & res_empty;
   // An operand written in the same cycle as an accepted go into an empty FIFO
   // is forwarded straight to act_x instead of being stored.
   assign op_push  = in_wr & ~(go_ok & op_empty);
   assign res_pop  = bus.out_ready & ~res_empty;

`ifdef TANHX_STREAM_TIMEOUT_EN
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          err_q, err_d;
`else
   localparam int unsigned unused_timeout = TIMEOUT;
`endif

   sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_op_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (op_push),
      .pop   (op_pop),
      .flush (flush),
      .wdata (bus.in_data),
      .rdata (op_rdata),
      .full  (op_full),
      .empty (op_empty),
      .count (op_count)
   );

   sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_res_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (res_push),
      .pop   (res_pop),
      .flush (flush),
      .wdata (bus.act_y),
      .rdata (res_rdata),
      .full  (res_full_unused),
      .empty (res_empty),
      .count (res_count_unused)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         n_q         <= '0;
         sent_q      <= '0;
         recv_q      <= '0;
         act_start_q <= 1'b0;
         act_x_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         sent_q      <= sent_d;
         recv_q      <= recv_d;
         act_start_q <= act_start_d;
         act_x_q     <= act_x_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef TANHX_STREAM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      sent_d      = sent_q;
      recv_d      = recv_q;
      act_start_d = act_start_q;
      act_x_d     = DWIDTH'(FP32_ZERO);
      busy_d      = busy_q;
      done_d      = 1'b0;
      op_pop      = 1'b0;
      res_push    = 1'b0;
      flush       = 1'b0;
`ifdef TANHX_STREAM_TIMEOUT_EN
      wd_d        = wd_q;
      err_d       = err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            act_start_d = 1'b0;
            busy_d      = 1'b0;
            if (go_ok) begin
               // Operand 0 leaves at the accepting edge, so sent starts at 1.
               n_d         = n_avail;
               sent_d      = CW'(1);
               recv_d      = '0;
               act_start_d = 1'b1;
               busy_d      = 1'b1;
               act_x_d     = op_empty ? bus.in_data : op_rdata;
               op_pop      = ~op_empty;
               state_d     = ST_STREAM;
`ifdef TANHX_STREAM_TIMEOUT_EN
               wd_d        = '0;
               err_d       = 1'b0;
`endif
            end
         end

         ST_STREAM: begin
            if (sent_q < n_q) begin
               act_x_d = op_rdata;
               op_pop  = 1'b1;
               sent_d  = sent_q + 1'b1;
            end
            if (bus.act_valid && (recv_q < n_q)) begin
               res_push = 1'b1;
               recv_d   = recv_q + 1'b1;
               if (recv_d == n_q) begin
                  act_start_d = 1'b0;
                  done_d      = 1'b1;
                  act_x_d     = DWIDTH'(FP32_ZERO);
                  state_d     = ST_FINISH;
               end
            end
`ifdef TANHX_STREAM_TIMEOUT_EN
            if (bus.act_valid) begin
               wd_d = '0;
            end else if (wd_q == WW'(TIMEOUT - 1)) begin
               err_d       = 1'b1;
               flush       = 1'b1;
               op_pop      = 1'b0;
               sent_d      = sent_q;
               act_start_d = 1'b0;
               act_x_d     = DWIDTH'(FP32_ZERO);
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end

         ST_FINISH: begin
            act_start_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end

         default: begin
            act_start_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.out_valid = ~res_empty;
   assign bus.out_data  = res_rdata;
   assign bus.act_start = act_start_q;
   assign bus.act_x     = act_x_q;
`ifdef TANHX_STREAM_TIMEOUT_EN
   assign bus.err_timeout = err_q;
`else
   assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tanhx_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tanhx_stream_ctrl
// Directed bench for tanhx_stream_ctrl. A stub unit returns ~x for every
// act_start cycle, at least 3 cycles later, strictly in order; it can be
// disabled (never valid) or paused (drop) to create gaps.
// Honors TANHX_STREAM_TIMEOUT_EN for the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_tanhx_stream_ctrl;
   import tanhx_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   tanhx_stream_ctrl_if #(.DWIDTH(32)) ifc ();

   tanhx_stream_ctrl #(.DWIDTH(32), .DEPTH(16), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // ---------------- stub activation unit ----------------
   logic        stub_en = 1'b1;
   logic        drop    = 1'b0;
   int          cyc     = 0;
   logic [31:0] sq_x [$];
   int          sq_t [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rst || !ifc.act_start) begin
         sq_x.delete();
         sq_t.delete();
      end else begin
         sq_x.push_back(ifc.act_x);
         sq_t.push_back(cyc);
      end
      if (rst) begin
         ifc.act_valid <= 1'b0;
         ifc.act_y     <= '0;
      end else if (stub_en && !drop && sq_x.size() > 0 && (cyc - sq_t[0]) >= 2) begin
         ifc.act_valid <= 1'b1;
         ifc.act_y     <= ~sq_x.pop_front();
         sq_t.pop_front();
      end else begin
         ifc.act_valid <= 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic write_op(input logic [31:0] x);
      ifc.in_valid = 1'b1;
      ifc.in_data  = x;
      tick();
      ifc.in_valid = 1'b0;
   endtask

   // Returns in the first cycle after the go edge (k = 1).
   task automatic pulse_go();
      ifc.go = 1'b1;
      tick();
      ifc.go = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int unsigned budget);
      for (int unsigned i = 0; i < budget; i++) begin
         if (ifc.done) break;
         tick();
      end
      check(tag, ifc.done, 1'b1);
   endtask

   task automatic pop_check(input string tag, input logic [31:0] exp);
      check({tag, "_valid"}, ifc.out_valid, 1'b1);
      check({tag, "_data"}, ifc.out_data, exp);
      ifc.out_ready = 1'b1;
      tick();
      ifc.out_ready = 1'b0;
   endtask

   // Test-1 per-cycle expectations, bit/index k-1 for cycle k after go edge.
   logic [31:0] t1_x [8] = '{32'h3F00_0000, 32'hBF80_0000, 32'h4080_0000,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
   logic [7:0]  t1_start = 8'b0011_1111;
   logic [7:0]  t1_done  = 8'b0100_0000;
   logic [7:0]  t1_busy  = 8'b0111_1111;
   logic [7:0]  t1_oval  = 8'b1111_0000;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int unsigned dcnt;
      int unsigned dk;

      ifc.in_valid  = 1'b0;
      ifc.in_data   = '0;
      ifc.go        = 1'b0;
      ifc.out_ready = 1'b0;

      // ---- reset values ----
      do_reset();
      check("rst_act_start", ifc.act_start, 1'b0);
      check("rst_act_x", ifc.act_x, 32'h0);
      check("rst_busy", ifc.busy, 1'b0);
      check("rst_done", ifc.done, 1'b0);
      check("rst_err", ifc.err_timeout, 1'b0);
      check("rst_out_valid", ifc.out_valid, 1'b0);
      check("rst_in_ready", ifc.in_ready, 1'b1);

      // ---- test 1: three-operand burst, latency 3 ----
      write_op(32'h3F00_0000);
      write_op(32'hBF80_0000);
      write_op(32'h4080_0000);
      pulse_go();
      check("t1_in_ready_stream", ifc.in_ready, 1'b0);
      for (int unsigned k = 1; k <= 8; k++) begin
         check($sformatf("t1_start_k%0d", k), ifc.act_start, t1_start[k-1]);
         check($sformatf("t1_x_k%0d", k), ifc.act_x, t1_x[k-1]);
         check($sformatf("t1_done_k%0d", k), ifc.done, t1_done[k-1]);
         check($sformatf("t1_busy_k%0d", k), ifc.busy, t1_busy[k-1]);
         check($sformatf("t1_oval_k%0d", k), ifc.out_valid, t1_oval[k-1]);
         tick();
      end
      pop_check("t1_r0", 32'hC0FF_FFFF);
      pop_check("t1_r1", 32'h407F_FFFF);
      pop_check("t1_r2", 32'hBF7F_FFFF);
      check("t1_drained", ifc.out_valid, 1'b0);

      // ---- test 2: ignored go ----
      pulse_go();
      check("t2_empty_go_busy", ifc.busy, 1'b0);
      check("t2_empty_go_start", ifc.act_start, 1'b0);

      write_op(FP32_POS_ONE);
      pulse_go();
      wait_done("t2_first_done", 50);
      tick();
      write_op(FP32_NEG_ONE);
      pulse_go();
      check("t2_resfull_go_busy", ifc.busy, 1'b0);
      check("t2_resfull_go_start", ifc.act_start, 1'b0);
      check("t2_in_ready_idle", ifc.in_ready, 1'b1);
      pop_check("t2_r0", 32'hC07F_FFFF);
      pulse_go();
      check("t2_retry_busy", ifc.busy, 1'b1);
      wait_done("t2_retry_done", 50);
      tick();
      pop_check("t2_r1", 32'h407F_FFFF);
      check("t2_drained", ifc.out_valid, 1'b0);

      // ---- test 3: unit never answers ----
      stub_en = 1'b0;
      write_op(32'h3F00_0000);
      write_op(32'hBF80_0000);
      pulse_go();
`ifdef TANHX_STREAM_TIMEOUT_EN
      dcnt = 0;
      for (int unsigned k = 1; k <= 15; k++) begin
         if (ifc.done) dcnt++;
         if (k == 15) begin
            check("t3_start_k15", ifc.act_start, 1'b1);
            check("t3_err_k15", ifc.err_timeout, 1'b0);
         end
         tick();
      end
      check("t3_err_k16", ifc.err_timeout, 1'b1);
      check("t3_start_k16", ifc.act_start, 1'b0);
      check("t3_busy_k16", ifc.busy, 1'b0);
      check("t3_done_k16", ifc.done, 1'b0);
      check("t3_out_valid", ifc.out_valid, 1'b0);
      check("t3_done_count", dcnt, 0);
      pulse_go();
      check("t3_flushed_go_busy", ifc.busy, 1'b0);
      check("t3_err_sticky", ifc.err_timeout, 1'b1);
`else
      repeat (19) tick();
      check("t3_wait_start", ifc.act_start, 1'b1);
      check("t3_wait_busy", ifc.busy, 1'b1);
      check("t3_err_tied", ifc.err_timeout, 1'b0);
`endif
      stub_en = 1'b1;
      do_reset();

      // ---- test 4: full operand FIFO, results retained then drained ----
      for (int unsigned i = 0; i < 16; i++) begin
         check($sformatf("t4_ready_%0d", i), ifc.in_ready, 1'b1);
         write_op(32'h4000_0000 + i);
      end
      check("t4_ready_full", ifc.in_ready, 1'b0);
      write_op(32'h7F00_0000);
      pulse_go();
      check("t4_busy", ifc.busy, 1'b1);
      check("t4_err_clear", ifc.err_timeout, 1'b0);
      wait_done("t4_done", 100);
      tick();
      for (int unsigned i = 0; i < 16; i++) begin
         pop_check($sformatf("t4_r%0d", i), ~(32'h4000_0000 + i));
      end
      check("t4_drained", ifc.out_valid, 1'b0);

      // ---- test 5: two-cycle act_valid gap in a burst of 4 ----
      write_op(32'h3F80_0000);
      write_op(32'hBF80_0000);
      write_op(32'h4000_0000);
      write_op(32'hC000_0000);
      pulse_go();
      repeat (4) tick();
      drop = 1'b1;
      repeat (2) tick();
      drop = 1'b0;
      dcnt = 0;
      dk   = 0;
      for (int unsigned j = 0; j < 33; j++) begin
         if (ifc.done) begin
            dcnt++;
            dk = 7 + j;
         end
         tick();
      end
      check("t5_done_count", dcnt, 1);
      check("t5_done_cycle", dk, 10);
      pop_check("t5_r0", 32'hC07F_FFFF);
      pop_check("t5_r1", 32'h407F_FFFF);
      pop_check("t5_r2", 32'hBFFF_FFFF);
      pop_check("t5_r3", 32'h3FFF_FFFF);
      check("t5_drained", ifc.out_valid, 1'b0);

      // ---- test 6: reset after two of four captures ----
      write_op(32'h3F80_0000);
      write_op(32'hBF80_0000);
      write_op(32'h4000_0000);
      write_op(32'hC000_0000);
      pulse_go();
      repeat (5) tick();
      check("t6_pre_out_valid", ifc.out_valid, 1'b1);
      rst = 1'b1;
      tick();
      check("t6_start", ifc.act_start, 1'b0);
      check("t6_act_x", ifc.act_x, 32'h0);
      check("t6_out_valid", ifc.out_valid, 1'b0);
      check("t6_in_ready", ifc.in_ready, 1'b1);
      check("t6_busy", ifc.busy, 1'b0);
      check("t6_done", ifc.done, 1'b0);
      rst = 1'b0;
      tick();
      pulse_go();
      check("t6_cleared_go_busy", ifc.busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tanhx_stream_ctrl.md
# tanhx_stream_ctrl

Stream controller on the driving side of the tanh(x) activation unit. Buffers FP32 operands from a host, presents them to the unit as one contiguous burst, and captures the unit's results into a result buffer for host readout. It is the only block that drives the unit's start/operand inputs and consumes its valid/result outputs.

## Interface
- DWIDTH, 32, operand/result width (IEEE-754 single)
- DEPTH, 16, entries in each of the operand and result FIFOs (power of 2)
- TIMEOUT, 15, maximum consecutive STREAM cycles without act_valid before abort
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  host operand write strobe
- in_data  in  DWIDTH  host operand
- in_ready  out  1  operand FIFO accepts a write
- go  in  1  start a burst of all buffered operands
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- err_timeout  out  1  sticky watchdog error, cleared by rst or next accepted go
- out_valid  out  1  result FIFO non-empty
- out_data  out  DWIDTH  head of result FIFO
- out_ready  in  1  host pops result
- act_start  out  1  to unit start; held high for entire burst
- act_x  out  DWIDTH  to unit operand input
- act_valid  in  1  unit result valid
- act_y  in  DWIDTH  unit result

## Operation
- States: IDLE, STREAM, FINISH.
- IDLE: in_ready = operand FIFO not full. go accepted only if operand count (including a same-cycle accepted write) > 0 and result FIFO empty; otherwise ignored. On accept: latch n = count, clear sent/recv counters and err_timeout, go to STREAM.
- STREAM: in_ready = 0. act_start = 1. Each cycle act_x = next popped operand while sent < n; after n pops act_x = 0x00000000 (padding, keeps unit streaming). Every cycle with act_valid = 1 and recv < n: write act_y to result FIFO, recv++. act_y ignored when act_valid = 0. Results are in operand order.
- recv reaching n -> FINISH. FINISH: act_start = 0, done = 1, busy = 1, one cycle, then IDLE. Padding-derived results never captured.
- Watchdog: counter resets on each act_valid; reaching TIMEOUT in STREAM -> err_timeout = 1, both FIFOs flushed, act_start = 0, IDLE next cycle, no done.
- Result FIFO pops (out_valid & out_ready) allowed in any state.
- Counters sent/recv are $clog2(DEPTH)+1 bits; no wrap, n <= DEPTH.

## Timing
- Reset values: act_start 0, act_x 0, busy 0, done 0, err_timeout 0, out_valid 0, in_ready 1 (first cycle after rst), state IDLE, FIFOs empty.
- act_start, act_x, busy, done registered. go sampled at edge T -> act_start = 1 and act_x = operand 0 during cycle T+1.
- Capture: act_y sampled at edge ending the act_valid cycle; out_valid high the following cycle.
- Nth capture at edge T -> FINISH in cycle T+1 (act_start low, done high), IDLE at T+2.
- No assumption on unit latency; gaps in act_valid tolerated.
- rst mid-burst: next cycle all outputs at reset values, FIFOs cleared.
- Simultaneous result write and host pop on result FIFO: both occur, count unchanged.

## Configuration
- TANHX_STREAM_TIMEOUT_EN defined: watchdog as above.
- Undefined: no watchdog logic, err_timeout tied 0, STREAM waits indefinitely for n results; TIMEOUT unused.

## Structure
- Shared package tanhx_pkg: state enum, FP32 constants (FP32_ZERO padding, FP32_POS_ONE, FP32_NEG_ONE), default DWIDTH.
- Sub-module sync_fifo (DWIDTH, DEPTH; push/pop/flush, full/empty/count), instantiated twice.

## Test plan
- Write 0x3F000000, 0xBF800000, 0x40800000, go; stub unit latency 3 -> result FIFO holds three stub results in order, done pulses once, act_start high until cycle after 3rd capture, padding 0x00000000 seen on act_x after 3rd operand.
- go with empty operand FIFO, or with result FIFO non-empty -> ignored, busy stays 0.
- Stub never asserts act_valid, TIMEOUT = 15 -> err_timeout = 1 after 15 STREAM cycles, act_start 0 next cycle, both FIFOs empty, no done.
- 16 writes then 17th -> in_ready low at 17th; burst of 16 with out_ready low -> 16 results retained, then 16 pops drain, out_valid 0.
- Stub drops act_valid for 2 cycles mid-burst of 4 -> exactly 4 captures, no garbage, done once.
- rst after 2 of 4 captures -> next cycle act_start 0, out_valid 0, in_ready 1, busy 0.
